sqrt: RTL and testbench

//   Sequential integer square root for the calculator datapath.

---
 rtl/sqrt.sv | 159 +++++++++++++++
 tb/tb_sqrt.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sqrt.sv
// Sequential integer square root: result = floor(sqrt(A)) for an unsigned
// WIDTH-bit radicand. It uses a restoring digit-by-digit method that handles
// two radicand bits per clock, so one operation takes WIDTH/2 iterations.
// Optional build macro SQRT_ROUND_EN: the root is rounded to nearest instead
// of truncated. For that case the root register is one bit wider so that
// 2^(WIDTH/2) is representable.
module sqrt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int HALF  = WIDTH / 2;
  localparam int REM_W = HALF + 2;
  localparam int CNT_W = $clog2(HALF + 1);
`ifdef SQRT_ROUND_EN
  localparam int ROOT_W = HALF + 1;
`else
  localparam int ROOT_W = HALF;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   op_r;
  logic [REM_W-1:0]   rem_r;
  logic [ROOT_W-1:0]  root_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   result_r;
  logic               done_r;

  logic [REM_W-1:0]   rem_shift_s;
  logic [REM_W-1:0]   trial_s;
  logic               fits_s;
  logic [REM_W-1:0]   rem_next_s;
  logic [ROOT_W-1:0]  root_next_s;
  logic               last_iter_s;
  logic [ROOT_W-1:0]  final_root_s;
  logic [WIDTH-1:0]   result_next_s;

  // One restoring iteration: bring down two radicand bits and try subtracting {root,01}.
  always_comb begin
    rem_shift_s = (rem_r << 2) | {{HALF{1'b0}}, op_r[WIDTH-1:WIDTH-2]};
    trial_s     = {root_r[HALF-1:0], 2'b01};
    fits_s      = (rem_shift_s >= trial_s);
    if (fits_s) begin
      rem_next_s = rem_shift_s - trial_s;
    end else begin
      rem_next_s = rem_shift_s;
    end
    root_next_s = (root_r << 1) | {{(ROOT_W-1){1'b0}}, fits_s};
    last_iter_s = (cnt_r == CNT_W'(1));
  end

  // Final root selection; rounding up when the leftover remainder exceeds the root.
  always_comb begin
    final_root_s = root_r;
`ifdef SQRT_ROUND_EN
    if (rem_r > {{(REM_W-ROOT_W){1'b0}}, root_r}) begin
      final_root_s = root_r + ROOT_W'(1);
    end else begin
      final_root_s = root_r;
    end
`endif
    result_next_s = {{(WIDTH-ROOT_W){1'b0}}, final_root_s};
  end

  // Next-state logic for the IDLE -> CALC -> DONE -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_iter_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers: operand capture in IDLE, one iteration per clock in CALC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r   <= {WIDTH{1'b0}};
      rem_r  <= {REM_W{1'b0}};
      root_r <= {ROOT_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r   <= A;
            rem_r  <= {REM_W{1'b0}};
            root_r <= {ROOT_W{1'b0}};
            cnt_r  <= CNT_W'(HALF);
          end
        end
        CALC: begin
          rem_r  <= rem_next_s;
          root_r <= root_next_s;
          op_r   <= {op_r[WIDTH-3:0], 2'b00};
          cnt_r  <= cnt_r - CNT_W'(1);
        end
        default: begin
          op_r   <= op_r;
          rem_r  <= rem_r;
          root_r <= root_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs: result is updated only on completion, done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
    end else begin
      done_r <= (state_r == DONE);
      if (state_r == DONE) begin
        result_r <= result_next_s;
      end
    end
  end

  assign result = result_r;
  assign done   = done_r;

endmodule

// File: tb/tb_sqrt.sv
// Self-checking bench for sqrt: directed boundary cases, random radicands,
// reset abort, ignored start while busy, and back-to-back operation with
// start held high. Expected roots come from a plain arithmetic model.
module tb_sqrt;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] result;
  logic         done;

  int total = 0;
  int bad   = 0;

  sqrt #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference: smallest-r search for floor, nearest via (2r+1)^2 <= 4a.
  function automatic int ref_root(input int a);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
`ifdef SQRT_ROUND_EN
    if (4 * a >= (2 * r + 1) * (2 * r + 1)) r++;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_op(input logic [W-1:0] a, input string tag);
    int n;
    logic [W-1:0] prev;
    @(negedge clk);
    A = a; start = 1'b1; prev = result;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom);
    check({tag, " hold"}, 32'(result), 32'(prev));
    wait_done(n);
    check({tag, " lat"}, 32'(n), 32'd9);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " res"}, 32'(result), 32'(ref_root(int'(a))));
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int seen;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst res", 32'(result), 32'd0);
    check("rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // directed and boundary values
    run_op(16'd225, "a225");
    run_op(16'd0, "a0");
    run_op(16'd1, "a1");
    run_op(16'd2, "a2");
    run_op(16'd240, "a240");
    run_op(16'd241, "a241");
    run_op(16'hFFFF, "amax");

    // random radicands
    for (int i = 0; i < 25; i++) begin
      run_op(W'($urandom_range(0, 65535)), "rand");
    end

    // reset in the middle of CALC
    run_op(16'd225, "pre-abort");
    @(negedge clk);
    A = 16'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort res", 32'(result), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);
    check("abort res held", 32'(result), 32'd0);
    run_op(16'd144, "post-abort");

    // start while busy is ignored
    @(negedge clk);
    A = 16'd225; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("busy lat", 32'(n), 32'd5);
    check("busy res", 32'(result), 32'(ref_root(225)));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("busy not queued", 32'(seen), 32'd0);
    run_op(16'd100, "fresh100");

    // start held high: back-to-back with one IDLE cycle, A changes after capture
    @(negedge clk);
    A = 16'd49; start = 1'b1;
    @(posedge clk); #1;
    A = 16'd64;
    wait_done(n);
    check("b2b lat1", 32'(n), 32'd9);
    check("b2b res1", 32'(result), 32'(ref_root(49)));
    wait_done(n);
    start = 1'b0;
    check("b2b lat2", 32'(n), 32'd10);
    check("b2b res2", 32'(result), 32'(ref_root(64)));
    @(posedge clk); #1;
    check("b2b pulse", 32'(done), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("b2b stop", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
